// File: rtl/lieat_wbck_sched.sv
// Writeback scheduler: long-instruction tag table, hazard check, and arbitration onto the single regfile write port.
// Define LIEAT_LONGI_PRIO_EN to give long-instruction completions priority over the pipeline.
module lieat_wbck_sched #(
  parameter int unsigned LONGI_DEPTH = 4,
  parameter int unsigned LIDX        = 2,
  parameter int unsigned REG_IDX     = 5,
  parameter int unsigned XLEN        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [REG_IDX-1:0] disp_rd,
  output logic [LIDX-1:0]    disp_itag,
  input  logic [REG_IDX-1:0] chk_rs1,
  input  logic [REG_IDX-1:0] chk_rs2,
  input  logic [REG_IDX-1:0] chk_rd,
  output logic               chk_hazard,
  input  logic               pipe_wb_valid,
  output logic               pipe_wb_ready,
  input  logic               pipe_wb_en,
  input  logic [REG_IDX-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]    pipe_wb_data,
  input  logic [XLEN-1:0]    pipe_wb_pc,
  input  logic               pipe_wb_ebreak,
  input  logic               longi_wb_valid,
  output logic               longi_wb_ready,
  input  logic [LIDX-1:0]    longi_wb_itag,
  input  logic [XLEN-1:0]    longi_wb_data,
  input  logic [XLEN-1:0]    longi_wb_pc,
  output logic               rf_wb_valid,
  output logic               rf_wb_en,
  output logic [REG_IDX-1:0] rf_wb_rd,
  output logic [XLEN-1:0]    rf_wb_data,
  output logic [XLEN-1:0]    rf_wb_pc,
  output logic               rf_wb_lsu,
  output logic               rf_wb_ebreak,
  output logic               longi_empty
);

  logic [LONGI_DEPTH-1:0] vld;
  logic [REG_IDX-1:0]     ent_rd [LONGI_DEPTH];
  logic [LIDX-1:0]        out_itag;
  logic                   out_from_longi;

  logic [LONGI_DEPTH-1:0] rel_mask;
  logic [LONGI_DEPTH-1:0] alloc_mask;
  logic                   disp_fire;
  logic                   found;
  logic                   longi_live;
  logic                   pipe_grant;
  logic                   longi_grant;
  logic [REG_IDX-1:0]     longi_rd;

  // Lowest-index free entry; an entry being released this cycle still counts as busy.
  always_comb begin
    disp_itag = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(LONGI_DEPTH); i++) begin
      if (!vld[i] && !found) begin
        disp_itag = LIDX'(i);
        found     = 1'b1;
      end
    end
    disp_ready = found;
  end

  always_comb begin
    chk_hazard = 1'b0;
    for (int i = 0; i < int'(LONGI_DEPTH); i++) begin
      if (vld[i] && (ent_rd[i] != '0) &&
          ((ent_rd[i] == chk_rs1) || (ent_rd[i] == chk_rs2) || (ent_rd[i] == chk_rd)))
        chk_hazard = 1'b1;
    end
  end

  // Release happens as the output register presents the write, so the hazard outlives the data hazard window.
  always_comb begin
    rel_mask   = '0;
    alloc_mask = '0;
    disp_fire  = disp_valid & disp_ready;
    if (rf_wb_valid && out_from_longi)
      rel_mask[out_itag] = 1'b1;
    if (disp_fire)
      alloc_mask[disp_itag] = 1'b1;
  end

  assign longi_live  = vld[longi_wb_itag] & ~rel_mask[longi_wb_itag];
  assign longi_rd    = ent_rd[longi_wb_itag];
  assign longi_empty = ~|vld;

`ifdef LIEAT_LONGI_PRIO_EN
  assign longi_wb_ready = 1'b1;
  assign pipe_wb_ready  = ~longi_wb_valid;
  assign longi_grant    = longi_wb_valid;
  assign pipe_grant     = pipe_wb_valid & ~longi_wb_valid;
`else
  assign pipe_wb_ready  = 1'b1;
  assign longi_wb_ready = ~pipe_wb_valid;
  assign pipe_grant     = pipe_wb_valid;
  assign longi_grant    = longi_wb_valid & ~pipe_wb_valid;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld <= '0;
    else       vld <= (vld & ~rel_mask) | alloc_mask;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(LONGI_DEPTH); i++)
      if (alloc_mask[i]) ent_rd[i] <= disp_rd;
  end

  // Write-port output stage; a completion naming a dead entry is consumed silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_wb_valid    <= 1'b0;
      rf_wb_en       <= 1'b0;
      rf_wb_rd       <= '0;
      rf_wb_data     <= '0;
      rf_wb_pc       <= '0;
      rf_wb_lsu      <= 1'b0;
      rf_wb_ebreak   <= 1'b0;
      out_itag       <= '0;
      out_from_longi <= 1'b0;
    end else if (pipe_grant) begin
      rf_wb_valid    <= 1'b1;
      rf_wb_en       <= pipe_wb_en;
      rf_wb_rd       <= pipe_wb_rd;
      rf_wb_data     <= pipe_wb_data;
      rf_wb_pc       <= pipe_wb_pc;
      rf_wb_lsu      <= 1'b0;
      rf_wb_ebreak   <= pipe_wb_ebreak;
      out_itag       <= '0;
      out_from_longi <= 1'b0;
    end else if (longi_grant && longi_live) begin
      rf_wb_valid    <= 1'b1;
      rf_wb_en       <= (longi_rd != '0);
      rf_wb_rd       <= longi_rd;
      rf_wb_data     <= longi_wb_data;
      rf_wb_pc       <= longi_wb_pc;
      rf_wb_lsu      <= 1'b1;
      rf_wb_ebreak   <= 1'b0;
      out_itag       <= longi_wb_itag;
      out_from_longi <= 1'b1;
    end else begin
      rf_wb_valid    <= 1'b0;
      rf_wb_en       <= 1'b0;
      rf_wb_rd       <= '0;
      rf_wb_data     <= '0;
      rf_wb_pc       <= '0;
      rf_wb_lsu      <= 1'b0;
      rf_wb_ebreak   <= 1'b0;
      out_itag       <= '0;
      out_from_longi <= 1'b0;
    end
  end

endmodule
